key_schedule_ctrl: RTL

- Sequencer that drives one singleKeyExpansion stage, one round at a time, to build the full AES-128 key schedule.
- On start it stores the cipher key as round key 0. It then issues ten expansion steps and captures each expansion output as round keys 1..10 in an internal 11-entry key store.
- The round datapath reads round keys through a registered read port.

---
 rtl/key_schedule_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/key_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// key_schedule_ctrl
//
// Sequencer that drives a single AES-128 singleKeyExpansion stage one round at
// a time and collects the complete key schedule (round keys 0..ROUNDS) in an
// internal key store. The round datapath reads keys back through a registered
// read port.
//
// Round timing, counting the cycle after the accepting start edge as cycle 1:
//   round r : SETUP in cycle 3r-2, EXP (enable) in 3r-1, CAP (capture) in 3r
//   DONE    : cycle 3*ROUNDS+1, done pulses and keys_valid rises
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        begin a schedule build (only acted on in IDLE)
//   cipher_key   round key 0, sampled on the accepting start edge
//   exp_key_in   previous round key, to expansion stage keyInput
//   exp_key_num  round index 1..ROUNDS, to expansion stage keyNum
//   exp_enable   expansion stage enable (one pulse per round)
//   exp_key_out  expansion stage keyOutput, valid the cycle after enable
//   busy         build in progress (SETUP/EXP/CAP)
//   done         one-cycle pulse once every round key is stored
//   keys_valid   key store holds a complete schedule
//   rd_addr      round key index to read
//   rd_reverse   (KEY_SCHED_REVERSE_RD_EN only) read slot ROUNDS-rd_addr
//   rd_key       registered read data, 0 when invalid or out of range
//
// Optional feature macro: KEY_SCHED_REVERSE_RD_EN adds the rd_reverse input
// for decryption-order reads.
// -----------------------------------------------------------------------------
module key_schedule_ctrl #(
    parameter int ROUNDS = 10,
    parameter int KEY_W  = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] cipher_key,
    output logic [KEY_W-1:0] exp_key_in,
    output logic [3:0]       exp_key_num,
    output logic             exp_enable,
    input  logic [KEY_W-1:0] exp_key_out,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    input  logic [3:0]       rd_addr,
`ifdef KEY_SCHED_REVERSE_RD_EN
    input  logic             rd_reverse,
`endif
    output logic [KEY_W-1:0] rd_key
);

    localparam logic [3:0] ROUNDS_4 = 4'(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EXP,
        S_CAP,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [3:0]       round;
    logic [KEY_W-1:0] cur_key;
    logic [KEY_W-1:0] slots [0:ROUNDS];
    logic [3:0]       rd_idx;

    logic             accept;
    logic             last_round;

    assign accept     = (state == S_IDLE) && start;
    assign last_round = (round == ROUNDS_4);

    // The expansion inputs come straight from registers that only change on
    // the edge entering SETUP, so they are stable before, during and after
    // the enable pulse and simply hold their last values in IDLE/DONE.
    assign exp_key_in  = cur_key;
    assign exp_key_num = round;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        exp_enable = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                busy       = 1'b1;
                state_next = S_EXP;
            end
            S_EXP: begin
                busy       = 1'b1;
                exp_enable = 1'b1;
                state_next = S_CAP;
            end
            S_CAP: begin
                busy       = 1'b1;
                state_next = last_round ? S_DONE : S_SETUP;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Round counter, current key and key store
    // -------------------------------------------------------------------------
    // cur_key is only advanced on non-final captures: the final round key is
    // already in the store, and leaving cur_key alone keeps exp_key_in at the
    // value it had during the last expansion.
    // NOTE: the key store is cleared by reset so a read after an aborted build
    // can never expose stale keys from an earlier schedule.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            round      <= '0;
            cur_key    <= '0;
            keys_valid <= 1'b0;
            for (int i = 0; i <= ROUNDS; i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (accept) begin
                slots[0]   <= cipher_key;
                cur_key    <= cipher_key;
                round      <= 4'd1;
                keys_valid <= 1'b0;
            end
            if (state == S_CAP) begin
                slots[round] <= exp_key_out;
                if (last_round) begin
                    keys_valid <= 1'b1;
                end else begin
                    cur_key <= exp_key_out;
                    round   <= round + 4'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered read port
    // -------------------------------------------------------------------------
    // The range check is always on rd_addr itself; in reverse mode the mapped
    // index ROUNDS-rd_addr is then guaranteed to be in range as well.
`ifdef KEY_SCHED_REVERSE_RD_EN
    assign rd_idx = rd_reverse ? (ROUNDS_4 - rd_addr) : rd_addr;
`else
    assign rd_idx = rd_addr;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_key <= '0;
        end else if (keys_valid && (rd_addr <= ROUNDS_4)) begin
            rd_key <= slots[rd_idx];
        end else begin
            rd_key <= '0;
        end
    end

endmodule
